// File: rtl/ram_pkg.sv
// Shared types and default sizing for the self-clearing simple dual-port RAM.
package ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array with one write port and a registered read port.
// Defining RAM_SDP_CLR_FWD_EN makes same-address read/write return the new data.
module ram_sdp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              fwd_hit;
  logic [DATA_W-1:0] rd_word;

  // The array is deliberately unreset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef RAM_SDP_CLR_FWD_EN
  assign fwd_hit = wr_en && rd_en && (wr_addr == rd_addr);
`else
  assign fwd_hit = 1'b0;
`endif

  assign rd_word = fwd_hit ? wr_data : mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM that sweeps itself to zero after reset or on clr_req.
// Optional write-first forwarding is enabled with the macro RAM_SDP_CLR_FWD_EN.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic              core_wr_en;
  logic [ADDR_W-1:0] core_wr_addr;
  logic [DATA_W-1:0] core_wr_data;

  assign busy  = (state == ST_CLEAR);
  assign idle  = (state == ST_IDLE);
  assign wr_ok = idle && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_ok = idle && rd_en && ({1'b0, rd_addr} < DEPTH_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // The sweep borrows the write port; user accesses are refused meanwhile.
  assign core_wr_en   = busy || wr_ok;
  assign core_wr_addr = busy ? clr_cnt : wr_addr;
  assign core_wr_data = busy ? '0 : wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
    end
  end

  ram_sdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (core_wr_en),
    .wr_addr  (core_wr_addr),
    .wr_data  (core_wr_data),
    .rd_en    (rd_ok),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed table-driven bench for ram_sdp_clr, with a DEPTH=12 instance for range errors.
module tb_ram_sdp_clr;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_req;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic       busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       err;

  logic       busy12;
  logic [7:0] rd_data12;
  logic       rd_valid12;
  logic       err12;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RAM_SDP_CLR_FWD_EN
  localparam logic [7:0] SAME_ADDR_EXP = 8'h3C;
`else
  localparam logic [7:0] SAME_ADDR_EXP = 8'h11;
`endif

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_err;
    string      name;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  ram_sdp_clr dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err)
  );

  ram_sdp_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut12 (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy12),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data12),
    .rd_valid (rd_valid12),
    .err      (err12)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                input logic re, input logic [3:0] ra, input logic clr);
    @(negedge clk);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    clr_req = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until busy drops, bounded so a stuck sweep still ends the test.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h00,         1'b1, 1'b0, "rd5_after_clear"};
    vecs[1]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00,         1'b0, 1'b0, "wr3_hold"};
    vecs[2]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'hA5,         1'b1, 1'b0, "rd3"};
    vecs[3]  = '{1'b1, 4'd7,  8'h11, 1'b1, 4'd3,  8'hA5,         1'b1, 1'b0, "wr7_rd3_diff"};
    vecs[4]  = '{1'b1, 4'd7,  8'h3C, 1'b1, 4'd7,  SAME_ADDR_EXP, 1'b1, 1'b0, "same_addr_rw"};
    vecs[5]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  8'h3C,         1'b1, 1'b0, "rd7_new"};
    vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h3C,         1'b0, 1'b0, "idle_hold"};
    vecs[7]  = '{1'b1, 4'd15, 8'hFF, 1'b0, 4'd0,  8'h3C,         1'b0, 1'b0, "wr15_top"};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'hFF,         1'b1, 1'b0, "rd15_top"};
    vecs[9]  = '{1'b1, 4'd0,  8'h5A, 1'b1, 4'd15, 8'hFF,         1'b1, 1'b0, "wr0_rd15"};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  8'h5A,         1'b1, 1'b0, "rd0"};

    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    #1;
    check_output("reset_busy",     busy,     1);
    check_output("reset_rd_valid", rd_valid, 0);
    check_output("reset_rd_data",  rd_data,  0);
    check_output("reset_err",      err,      0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check_output("reset_sweep_len", n, 16);
    check_output("dut12_idle", busy12, 0);

    $display("[TB] running %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      apply_stimulus(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                     vecs[i].rd_en, vecs[i].rd_addr, 1'b0);
      tick();
      check_output({vecs[i].name, "_data"},  rd_data,  vecs[i].exp_data);
      check_output({vecs[i].name, "_valid"}, rd_valid, vecs[i].exp_valid);
      check_output({vecs[i].name, "_err"},   err,      vecs[i].exp_err);
    end

    // Out-of-range accesses on the DEPTH=12 instance; the 16-deep one accepts addr 13.
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    tick();
    check_output("d12_rd13_err",   err12,      1);
    check_output("d12_rd13_valid", rd_valid12, 0);
    check_output("d12_rd13_data",  rd_data12,  8'h5A);
    check_output("d16_rd13_err",   err,        0);
    check_output("d16_rd13_valid", rd_valid,   1);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    check_output("d12_err_pulse_end", err12, 0);
    apply_stimulus(1'b1, 4'd12, 8'h99, 1'b0, 4'd0, 1'b0);
    tick();
    check_output("d12_wr12_err", err12, 1);
    apply_stimulus(1'b1, 4'd11, 8'h66, 1'b0, 4'd0, 1'b0);
    tick();
    check_output("d12_wr11_err", err12, 0);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd11, 1'b0);
    tick();
    check_output("d12_rd11_data",  rd_data12,  8'h66);
    check_output("d12_rd11_valid", rd_valid12, 1);

    // clr_req with a read in the same cycle, then accesses and a second clr_req while busy.
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1);
    tick();
    check_output("clr_entry_busy",  busy,     1);
    check_output("clr_entry_valid", rd_valid, 1);
    check_output("clr_entry_data",  rd_data,  8'hA5);
    apply_stimulus(1'b1, 4'd3, 8'hEE, 1'b1, 4'd3, 1'b1);
    tick();
    check_output("busy_access_err",   err,      1);
    check_output("busy_access_valid", rd_valid, 0);
    check_output("busy_access_data",  rd_data,  8'hA5);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    check_output("busy_err_pulse_end", err, 0);
    count_busy(n);
    check_output("clr_sweep_len", n + 2, 16);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
    tick();
    check_output("rd3_after_clr", rd_data, 8'h00);
    check_output("rd3_after_clr_valid", rd_valid, 1);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b0);
    tick();
    check_output("rd15_after_clr", rd_data, 8'h00);

    // Reset in the middle of a sweep must restart it from address 0.
    apply_stimulus(1'b1, 4'd12, 8'h42, 1'b0, 4'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    check_output("mid_sweep_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy",  busy,     1);
    check_output("mid_rst_data",  rd_data,  0);
    check_output("mid_rst_valid", rd_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check_output("restart_sweep_len", n, 16);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b0);
    tick();
    check_output("rd12_after_restart",       rd_data,  8'h00);
    check_output("rd12_after_restart_valid", rd_valid, 1);
    apply_stimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    check_output("valid_drops", rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
